// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the UART block loader.
// Optional checksum stage is enabled by defining UART_LOADER_CHKSUM_EN.
package uart_loader_pkg;

`ifdef UART_LOADER_CHKSUM_EN
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StChk   = 2'd2,
    StIssue = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StIssue = 2'd3
  } state_e;
`endif

  localparam logic [3:0]  CMD_MAGIC_DEF = 4'hA;
  localparam int unsigned HDR_FIRST_BIT = 0;
  localparam int unsigned HDR_LAST_BIT  = 1;
  localparam int unsigned TIMEOUT_DEF   = 50000;

endpackage

// File: rtl/uart_loader_timer.sv
// Saturating inter-byte idle counter; expired_o is high while the count sits at Cycles.
module uart_loader_timer #(
  parameter int unsigned Cycles = 50000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW  = (Cycles > 0) ? $clog2(Cycles + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(Cycles);

  logic [CntW-1:0] count_q, count_d;

  // Clear wins over counting; the count holds once it reaches the limit.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != Limit)) begin
      count_d = count_q + CntW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == Limit);

endmodule

// File: rtl/uart_block_loader.sv
// Assembles UART bytes into fixed-size message blocks for a hash core.
// A header byte (magic in [7:4], first/last flags in [1:0]) opens a packet of
// BLOCK_BYTES payload bytes. Define UART_LOADER_CHKSUM_EN to require a trailing
// XOR checksum byte and expose err_chksum.
module uart_block_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES    = 64,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [3:0]  CMD_MAGIC      = CMD_MAGIC_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_break,
  output logic                     rx_en,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  output logic [8*BLOCK_BYTES-1:0] blk_data,
  output logic                     blk_first,
  output logic                     blk_last,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     err_drop
`ifdef UART_LOADER_CHKSUM_EN
 ,output logic                     err_chksum
`endif
);

  localparam int unsigned DataW = 8 * BLOCK_BYTES;
  localparam int unsigned CntW  = $clog2(BLOCK_BYTES + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(BLOCK_BYTES - 1);

  state_e           state_q;
  logic [DataW-1:0] data_q;
  logic [CntW-1:0]  cnt_q;
  logic             first_q, last_q;
  logic             blk_valid_q;
  logic             err_timeout_q, err_drop_q;
  logic             in_pkt;
  logic             timer_clr;
  logic             timer_expired;
`ifdef UART_LOADER_CHKSUM_EN
  logic [7:0]       chk_q;
  logic             err_chksum_q;
`endif

  // Idle timer runs only while a packet is being received.
`ifdef UART_LOADER_CHKSUM_EN
  assign in_pkt = (state_q == StLoad) || (state_q == StChk);
`else
  assign in_pkt = (state_q == StLoad);
`endif
  // Any received byte restarts the idle count, so a byte beats a coincident timeout.
  assign timer_clr = rx_valid || !in_pkt;

  uart_loader_timer #(
    .Cycles (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (timer_clr),
    .en_i      (in_pkt),
    .expired_o (timer_expired)
  );

  // Packet FSM with registered block and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      data_q        <= '0;
      cnt_q         <= '0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      blk_valid_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_drop_q    <= 1'b0;
`ifdef UART_LOADER_CHKSUM_EN
      chk_q         <= '0;
      err_chksum_q  <= 1'b0;
`endif
    end else begin
      err_timeout_q <= 1'b0;
      err_drop_q    <= 1'b0;
`ifdef UART_LOADER_CHKSUM_EN
      err_chksum_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          // Break bytes and non-magic bytes are silently ignored here.
          if (rx_valid && !rx_break && (rx_data[7:4] == CMD_MAGIC)) begin
            first_q <= rx_data[HDR_FIRST_BIT];
            last_q  <= rx_data[HDR_LAST_BIT];
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef UART_LOADER_CHKSUM_EN
            chk_q   <= rx_data;
`endif
            state_q <= StLoad;
          end
        end

        StLoad: begin
          if (rx_valid) begin
            if (rx_break) begin
              state_q <= StIdle;
              data_q  <= '0;
              cnt_q   <= '0;
            end else begin
              data_q <= (data_q << 8) | DataW'(rx_data);
              cnt_q  <= cnt_q + CntW'(1);
`ifdef UART_LOADER_CHKSUM_EN
              chk_q  <= chk_q ^ rx_data;
`endif
              if (cnt_q == LastIdx) begin
`ifdef UART_LOADER_CHKSUM_EN
                state_q <= StChk;
`else
                state_q     <= StIssue;
                blk_valid_q <= 1'b1;
`endif
              end
            end
          end else if (timer_expired) begin
            state_q       <= StIdle;
            err_timeout_q <= 1'b1;
            data_q        <= '0;
            cnt_q         <= '0;
          end
        end

`ifdef UART_LOADER_CHKSUM_EN
        StChk: begin
          if (rx_valid) begin
            if (rx_break) begin
              state_q <= StIdle;
              data_q  <= '0;
              cnt_q   <= '0;
            end else if (rx_data == chk_q) begin
              state_q     <= StIssue;
              blk_valid_q <= 1'b1;
            end else begin
              state_q      <= StIdle;
              err_chksum_q <= 1'b1;
              data_q       <= '0;
              cnt_q        <= '0;
            end
          end else if (timer_expired) begin
            state_q       <= StIdle;
            err_timeout_q <= 1'b1;
            data_q        <= '0;
            cnt_q         <= '0;
          end
        end
`endif

        StIssue: begin
          // Receiver stays enabled, so bytes here are lost and flagged.
          if (rx_valid) begin
            err_drop_q <= 1'b1;
          end
          if (blk_ready) begin
            blk_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StIdle;
          end
        end

        default: begin
          state_q     <= StIdle;
          blk_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_en       = 1'b1;
  assign blk_valid   = blk_valid_q;
  assign blk_data    = data_q;
  assign blk_first   = first_q;
  assign blk_last    = last_q;
  assign busy        = (state_q != StIdle);
  assign err_timeout = err_timeout_q;
  assign err_drop    = err_drop_q;
`ifdef UART_LOADER_CHKSUM_EN
  assign err_chksum  = err_chksum_q;
`endif

endmodule

// File: tb/tb_uart_block_loader.sv
// Directed self-checking bench for uart_block_loader (64-byte blocks, short timeout).
module tb_uart_block_loader;

  localparam int unsigned BB = 64;
  localparam int unsigned TO = 40;

  logic            clk;
  logic            reset;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic            rx_break;
  logic            rx_en;
  logic            blk_valid;
  logic            blk_ready;
  logic [8*BB-1:0] blk_data;
  logic            blk_first;
  logic            blk_last;
  logic            busy;
  logic            err_timeout;
  logic            err_drop;
`ifdef UART_LOADER_CHKSUM_EN
  logic            err_chksum;
`endif

  int checks;
  int errors;
  logic [8*BB-1:0] exp_data;

  uart_block_loader #(
    .BLOCK_BYTES    (BB),
    .TIMEOUT_CYCLES (TO),
    .CMD_MAGIC      (4'hA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_break    (rx_break),
    .rx_en       (rx_en),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .blk_data    (blk_data),
    .blk_first   (blk_first),
    .blk_last    (blk_last),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_drop    (err_drop)
`ifdef UART_LOADER_CHKSUM_EN
   ,.err_chksum  (err_chksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One byte strobe; returns on the falling edge after the capturing rising edge.
  task automatic send_byte(input logic [7:0] b, input logic brk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_break = brk;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_break = 1'b0;
  endtask

  // Header plus BB bytes base, base+1, ...; builds exp_data; appends checksum when enabled.
  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] base);
    logic [7:0] chk;
    logic [7:0] b;
    chk = hdr;
    exp_data = '0;
    send_byte(hdr, 1'b0);
    for (int i = 0; i < BB; i++) begin
      b = base + 8'(i);
      exp_data = {exp_data[8*BB-9:0], b};
      chk = chk ^ b;
      send_byte(b, 1'b0);
    end
`ifdef UART_LOADER_CHKSUM_EN
    send_byte(chk, 1'b0);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hA3;
    repeat (3) @(negedge clk);
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid got %b want 0", blk_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (blk_data !== '0) begin errors++; $display("FAIL reset_blk_data got %h want 0", blk_data); end
    checks++; if ({blk_first, blk_last, err_timeout, err_drop} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {blk_first, blk_last, err_timeout, err_drop});
    end
    checks++; if (rx_en !== 1'b1) begin errors++; $display("FAIL reset_rx_en got %b want 1", rx_en); end
    rx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    blk_ready = 1'b1;
    send_packet(8'hA3, 8'h00);
    checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", blk_valid); end
    checks++; if (blk_data[511:504] !== 8'h00) begin errors++; $display("FAIL basic_msb got %h want 00", blk_data[511:504]); end
    checks++; if (blk_data[7:0] !== 8'h3F) begin errors++; $display("FAIL basic_lsb got %h want 3f", blk_data[7:0]); end
    checks++; if (blk_data !== exp_data) begin errors++; $display("FAIL basic_data got %h want %h", blk_data, exp_data); end
    checks++; if ({blk_first, blk_last} !== 2'b11) begin errors++; $display("FAIL basic_flags got %b want 11", {blk_first, blk_last}); end
    @(negedge clk);
    checks++; if ({blk_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_done got %b want 00", {blk_valid, busy}); end
  endtask

  task automatic test_bad_header();
    send_byte(8'h55, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badhdr_busy got %b want 0", busy); end
    send_byte(8'hA3, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_break_busy got %b want 0", busy); end
    send_packet(8'hA1, 8'h80);
    checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL badhdr_valid got %b want 1", blk_valid); end
    checks++; if ({blk_first, blk_last} !== 2'b10) begin errors++; $display("FAIL badhdr_flags got %b want 10", {blk_first, blk_last}); end
    checks++; if (blk_data !== exp_data) begin errors++; $display("FAIL badhdr_data got %h want %h", blk_data, exp_data); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int pulses;
    int first_at;
    logic saw_valid;
    pulses = 0;
    first_at = -1;
    saw_valid = 1'b0;
    send_byte(8'hA0, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b0);
    for (int i = 1; i <= int'(TO) + 20; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
      if (blk_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_pulses got %0d want 1", pulses); end
    checks++; if (first_at < int'(TO) || first_at > int'(TO) + 2) begin
      errors++; $display("FAIL timeout_cycle got %0d want %0d..%0d", first_at, TO, TO + 2);
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid got %b want 0", saw_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [8*BB-1:0] held;
    logic stable;
    int drops;
    stable = 1'b1;
    drops = 0;
    blk_ready = 1'b0;
    send_packet(8'hA2, 8'h40);
    held = blk_data;
    checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", blk_valid); end
    checks++; if ({blk_first, blk_last} !== 2'b01) begin errors++; $display("FAIL bp_flags got %b want 01", {blk_first, blk_last}); end
    checks++; if (held !== exp_data) begin errors++; $display("FAIL bp_data got %h want %h", held, exp_data); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (err_drop === 1'b1) drops++;
      if (blk_valid !== 1'b1 || blk_data !== held) stable = 1'b0;
      rx_valid = (c == 3 || c == 9);
      rx_data  = 8'hEE;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    if (err_drop === 1'b1) drops++;
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable got %b want 1", stable); end
    checks++; if (drops != 2) begin errors++; $display("FAIL bp_drops got %0d want 2", drops); end
    blk_ready = 1'b1;
    @(negedge clk);
    checks++; if ({blk_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_handshake got %b want 00", {blk_valid, busy}); end
  endtask

  task automatic test_break();
    send_byte(8'hA3, 1'b0);
    for (int i = 0; i < 29; i++) send_byte(8'(i), 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy_before got %b want 1", busy); end
    send_byte(8'h1D, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL brk_busy_after got %b want 0", busy); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL brk_no_err got %b want 0", err_timeout); end
    send_packet(8'hA1, 8'hC0);
    checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL brk_fresh_valid got %b want 1", blk_valid); end
    checks++; if (blk_data !== exp_data) begin errors++; $display("FAIL brk_fresh_data got %h want %h", blk_data, exp_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_midpacket();
    send_byte(8'hA3, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({busy, blk_valid, err_timeout} !== 3'b000) begin
      errors++; $display("FAIL midreset got %b want 000", {busy, blk_valid, err_timeout});
    end
    @(negedge clk);
  endtask

`ifdef UART_LOADER_CHKSUM_EN
  task automatic test_chksum();
    logic [7:0] chk;
    chk = 8'hA3;
    send_byte(8'hA3, 1'b0);
    for (int i = 0; i < int'(BB); i++) begin
      chk = chk ^ 8'(i);
      send_byte(8'(i), 1'b0);
    end
    send_byte(chk ^ 8'hFF, 1'b0);
    checks++; if (err_chksum !== 1'b1) begin errors++; $display("FAIL chk_pulse got %b want 1", err_chksum); end
    checks++; if ({blk_valid, busy} !== 2'b00) begin errors++; $display("FAIL chk_state got %b want 00", {blk_valid, busy}); end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    rx_break = 1'b0;
    blk_ready = 1'b1;
    test_reset();
    test_basic();
    test_bad_header();
    test_timeout();
    test_backpressure();
    test_break();
    test_reset_midpacket();
`ifdef UART_LOADER_CHKSUM_EN
    test_chksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
